// File: rtl/ul_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : ul_cfg_arb
// Purpose  : Round-robin arbiter sharing one config generator among NUM_REQ
//            requesters, with response timeout, abort and inter-issue gap.
// Revision : 1.0 - initial release
// ============================================================================
module ul_cfg_arb #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023,
    parameter int GAP     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  syn_rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic                  ul_req,
    output logic [31:0]           ul_addr,
    input  logic                  ul_valid,
    output logic                  cfg_syn_rst,
    output logic                  busy
);

    localparam int          LW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] c_reset_addr = 32'hDEAD_BEEF;
    localparam logic [11:0] c_timeout    = 12'(TIMEOUT);
    localparam logic [3:0]  c_gap_last   = 4'(GAP - 1);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ISSUE = 6'b000010,
        S_WAIT  = 6'b000100,
        S_RESP  = 6'b001000,
        S_ABORT = 6'b010000,
        S_GAP   = 6'b100000
    } state_t;

    state_t               state_q,       state_d;
    logic [NUM_REQ-1:0]   gnt_q,         gnt_d;
    logic [31:0]          ul_addr_q,     ul_addr_d;
    logic [11:0]          wait_cnt_q,    wait_cnt_d;
    logic [3:0]           gap_cnt_q,     gap_cnt_d;
    logic [LW-1:0]        last_winner_q, last_winner_d;

    logic                 w_found;
    logic [LW-1:0]        w_idx;
    logic [LW-1:0]        w_win;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [31:0]          w_win_addr;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = LW'((int'(last_winner_q) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_oh   = '0;
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == LW'(i)) begin
                w_win_oh[i] = 1'b1;
                w_win_addr  = addr[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        ul_addr_d     = ul_addr_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        last_winner_d = last_winner_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d       = S_ISSUE;
                    gnt_d         = w_win_oh;
                    ul_addr_d     = w_win_addr;
                    last_winner_d = w_win;
                end
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (wait_cnt_q != c_timeout) begin
                    wait_cnt_d = wait_cnt_q + 12'd1;
                end
                // A response arriving on the timeout cycle still counts as success.
                if (ul_valid) begin
                    state_d = S_RESP;
                end else if (wait_cnt_q == c_timeout) begin
                    state_d = S_ABORT;
                end
            end
            S_RESP, S_ABORT: begin
                state_d   = S_GAP;
                gnt_d     = '0;
                gap_cnt_d = '0;
            end
            S_GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || syn_rst) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            ul_addr_q     <= c_reset_addr;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            last_winner_q <= LW'(NUM_REQ - 1);
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            ul_addr_q     <= ul_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = (state_q == S_RESP)  ? gnt_q : '0;
    assign err         = (state_q == S_ABORT) ? gnt_q : '0;
    assign ul_req      = (state_q == S_ISSUE);
    assign ul_addr     = ul_addr_q;
    assign busy        = (state_q != S_IDLE);
    // Soft reset is forwarded to the generator at once; hard reset suppresses it.
    assign cfg_syn_rst = ~rst & (syn_rst | (state_q == S_ABORT));

endmodule
`default_nettype wire

// File: tb/tb_ul_cfg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ul_cfg_arb
// Purpose  : Self-checking bench for ul_cfg_arb using a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ul_cfg_arb;

    localparam int NREQ      = 4;
    localparam int TIMEOUT_P = 15;
    localparam int GAP_P     = 4;

    logic                 clk;
    logic                 rst;
    logic                 syn_rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   addr;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [NREQ-1:0]      err;
    logic                 ul_req;
    logic [31:0]          ul_addr;
    logic                 ul_valid;
    logic                 cfg_syn_rst;
    logic                 busy;

    int          checks;
    int          failures;
    int          rr_last;
    logic [31:0] addr_tab [NREQ];

    ul_cfg_arb #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TIMEOUT_P),
        .GAP     (GAP_P)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .syn_rst     (syn_rst),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .ul_req      (ul_req),
        .ul_addr     (ul_addr),
        .ul_valid    (ul_valid),
        .cfg_syn_rst (cfg_syn_rst),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr();
        addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    endtask

    task automatic do_rst();
        rst      = 1'b1;
        syn_rst  = 1'b0;
        req      = '0;
        ul_valid = 1'b0;
        tick();
        tick();
        chk("rst_gnt",     gnt,         0);
        chk("rst_done",    done,        0);
        chk("rst_err",     err,         0);
        chk("rst_ul_req",  ul_req,      0);
        chk("rst_ul_addr", ul_addr,     32'hDEAD_BEEF);
        chk("rst_busy",    busy,        0);
        chk("rst_cfg",     cfg_syn_rst, 0);
        syn_rst = 1'b1;
        #1;
        chk("rst_masks_cfg", cfg_syn_rst, 0);
        syn_rst = 1'b0;
        rst     = 1'b0;
        tick();
        rr_last = NREQ - 1;
    endtask

    // One full transaction from an IDLE cycle: issue, wait, response or
    // timeout, gap, and back to IDLE. delay = cycles from ul_req to ul_valid.
    task automatic run_txn(input logic [3:0] mask, input int delay,
                           input bit drop, input bit stray);
        int          w;
        int          last_n;
        bit          ok;
        logic [3:0]  eg;
        logic [31:0] ea;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (w < 0 && mask[(rr_last + k) % NREQ]) w = (rr_last + k) % NREQ;
        end
        rr_last = w;
        eg      = 4'(1 << w);
        ea      = addr_tab[w];
        ok      = (delay >= 1) && (delay <= TIMEOUT_P + 1);
        last_n  = ok ? delay + 1 : TIMEOUT_P + 2;

        chk("idle_busy", busy, 0);
        req      = mask;
        ul_valid = stray;
        tick();
        for (int n = 0; n <= last_n; n++) begin
            chk("txn_gnt",     gnt,         eg);
            chk("txn_ul_req",  ul_req,      (n == 0) ? 1 : 0);
            chk("txn_ul_addr", ul_addr,     ea);
            chk("txn_busy",    busy,        1);
            chk("txn_done",    done,        (ok && n == last_n) ? eg : 4'b0);
            chk("txn_err",     err,         (!ok && n == last_n) ? eg : 4'b0);
            chk("txn_cfg",     cfg_syn_rst, (!ok && n == last_n) ? 1 : 0);
            ul_valid = (n == delay);
            if (drop && n == 1) req = '0;
            if (n == 0) addr = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        for (int g = 0; g < GAP_P; g++) begin
            chk("gap_gnt",     gnt,         0);
            chk("gap_done",    done,        0);
            chk("gap_err",     err,         0);
            chk("gap_ul_req",  ul_req,      0);
            chk("gap_busy",    busy,        1);
            chk("gap_ul_addr", ul_addr,     ea);
            chk("gap_cfg",     cfg_syn_rst, 0);
            ul_valid = stray && (g % 2 == 1);
            tick();
        end
        ul_valid = 1'b0;
        chk("post_gnt",  gnt,  0);
        chk("post_done", done, 0);
        chk("post_err",  err,  0);
        chk("post_busy", busy, 0);
    endtask

    logic [3:0] r_mask;
    int         r_delay;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        syn_rst  = 1'b0;
        req      = '0;
        ul_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) addr_tab[i] = 32'h1000 + 32'(i);
        set_addr();
        do_rst();

        // Single requester, response five cycles after the issue pulse.
        addr_tab[0] = 32'h10;
        set_addr();
        run_txn(4'b0001, 5, 1'b0, 1'b0);

        // All requesters held high: fair rotation from a fresh reset.
        do_rst();
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < NREQ; i++) addr_tab[i] = 32'hA000_0000 + 32'(t * 16 + i);
            set_addr();
            run_txn(4'b1111, 2 + t, 1'b0, 1'b0);
        end

        // No response: timeout abort, then a normal transaction still completes.
        set_addr();
        run_txn(4'b0100, TIMEOUT_P + 10, 1'b0, 1'b0);
        set_addr();
        run_txn(4'b0100, 3, 1'b0, 1'b0);

        // Response on the exact timeout cycle wins over the abort.
        set_addr();
        run_txn(4'b0010, TIMEOUT_P + 1, 1'b0, 1'b0);

        // Request dropped mid-wait plus stray responses in IDLE and GAP.
        set_addr();
        run_txn(4'b1000, 4, 1'b1, 1'b1);

        // Soft reset in the middle of a wait.
        addr_tab[0] = 32'hCAFE_0001;
        set_addr();
        req = 4'b0001;
        tick();
        chk("sr_ul_req", ul_req, 1);
        tick();
        tick();
        syn_rst = 1'b1;
        req     = '0;
        #1;
        chk("sr_cfg_pulse", cfg_syn_rst, 1);
        tick();
        syn_rst = 1'b0;
        #1;
        chk("sr_gnt",     gnt,         0);
        chk("sr_ul_addr", ul_addr,     32'hDEAD_BEEF);
        chk("sr_busy",    busy,        0);
        chk("sr_cfg_off", cfg_syn_rst, 0);
        chk("sr_done",    done,        0);
        chk("sr_err",     err,         0);
        ul_valid = 1'b1;
        tick();
        ul_valid = 1'b0;
        chk("sr_late_done", done, 0);
        chk("sr_late_busy", busy, 0);
        rr_last = NREQ - 1;

        // Randomized traffic against the transaction model.
        for (int t = 0; t < 30; t++) begin
            r_mask  = 4'($urandom_range(1, 15));
            r_delay = int'($urandom_range(1, TIMEOUT_P + 4));
            for (int i = 0; i < NREQ; i++) addr_tab[i] = $urandom();
            set_addr();
            run_txn(r_mask, r_delay, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ul_cfg_arb.md
UL_CFG_ARB -- requirements
Module: ul_cfg_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of operator requesters sharing one config generator (2..8).
REQ-002 Parameter TIMEOUT, default 1023: maximum WAIT cycles before a transaction is aborted (1..4095).
REQ-003 Parameter GAP, default 4: idle cycles enforced after every transaction before the next issue (1..15).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 syn_rst  in  1  soft reset from CSR.
REQ-008 req  in  NUM_REQ  level request per requester; held until done or err.
REQ-009 addr  in  NUM_REQ*32  per-requester config address; slice i is addr[32*i+31:32*i].
REQ-010 gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-011 done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-012 err  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-013 ul_req  out  1  one-cycle request pulse to the config generator.
REQ-014 ul_addr  out  32  address to the config generator, stable from ISSUE through RESP.
REQ-015 ul_valid  in  1  config-generator response pulse.
REQ-016 cfg_syn_rst  out  1  soft-reset pulse to the config generator.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP, ABORT, GAP; all registered, one-hot encoded.
REQ-019 IDLE -> ISSUE when |req; the winner is latched into gnt and addr[winner] into ul_addr on the same edge.
REQ-020 Arbitration is round-robin: the search starts at last_winner+1 mod NUM_REQ; last_winner resets to NUM_REQ-1, so requester 0 wins first.
REQ-021 ISSUE lasts 1 cycle with ul_req=1, then moves to WAIT.
REQ-022 WAIT -> RESP on ul_valid; WAIT -> ABORT when wait_cnt==TIMEOUT; if both occur in the same cycle, ul_valid wins.
REQ-023 wait_cnt clears on entry to WAIT and increments each WAIT cycle; it saturates and does not wrap.
REQ-024 RESP lasts 1 cycle with done=gnt, then moves to GAP.
REQ-025 ABORT lasts 1 cycle with err=gnt and cfg_syn_rst=1, then moves to GAP.
REQ-026 GAP: gnt=0 and ul_addr holds its value; after GAP cycles the FSM returns to IDLE.
REQ-027 A requester that still has req high in IDLE is treated as a new request and arbitrated normally.
REQ-028 If req drops after grant, the transaction still completes and done/err still pulses.
REQ-029 ul_valid outside WAIT is ignored and produces no done.
REQ-030 ul_req SHALL assert only in ISSUE; it never asserts twice per transaction.
REQ-031 At most one bit of gnt|done|err is high in any cycle.
REQ-032 Latency: req rising in IDLE at cycle T gives gnt and ul_req at T+1; ul_valid at cycle V gives done at V+1.

Reset
REQ-033 rst or syn_rst forces IDLE on the next edge; gnt, done, err, ul_req=0; ul_addr=32'hDEAD_BEEF; wait_cnt and the gap counter =0; last_winner=NUM_REQ-1; busy=0.
REQ-034 syn_rst additionally drives cfg_syn_rst=1 in the same cycle (combinational pass-through); under rst, cfg_syn_rst=0.
REQ-035 A reset in the middle of a transaction aborts it with no done or err pulse.

Verification
REQ-036 req=4'b0001, addr0=32'h10, ul_valid 5 cycles after ul_req -> gnt=0001 and ul_req at T+1, ul_addr=32'h10, done=0001 one cycle after ul_valid, then GAP=4 idle cycles.
REQ-037 req=4'b1111 held high -> grant order 0,1,2,3,0, each transaction separated by at least GAP+1 cycles of gnt=0.
REQ-038 No ul_valid, TIMEOUT=15 -> err=granted bit and cfg_syn_rst pulse at wait_cnt==15; done never asserts; next request still served.
REQ-039 ul_valid in the same cycle wait_cnt==TIMEOUT -> done asserts, err does not.
REQ-040 syn_rst during WAIT -> IDLE next cycle, gnt=0, ul_addr=32'hDEAD_BEEF, cfg_syn_rst=1 for that cycle; a later ul_valid is ignored.
REQ-041 Stray ul_valid in IDLE and GAP -> no done; req dropped mid-WAIT -> done still pulses.
